// File: rtl/data_bus_control.sv
// Data bus controller: byte-addressed little-endian data RAM plus one
// memory-mapped 32-bit output register. Reads are combinational, writes
// commit on the rising clock edge, and every access completes in one cycle.
module data_bus_control #(
  parameter int          DATA_ADDR_WIDTH = 10,
  parameter logic [31:0] IO_BASE         = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wd,
  input  logic        rd,
  input  logic [1:0]  size_in,
  input  logic [1:0]  size_out,
  input  logic [31:0] addr_in,
  input  logic [31:0] addr_out,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        addr_misaligned,
  output logic        access_fault,
  output logic [31:0] gpio_out
);

  localparam int DEPTH = 2 ** DATA_ADDR_WIDTH;

  typedef struct packed {
    logic mis;
    logic fault;
    logic ram;
    logic io;
  } dec_t;

  logic [7:0]  mem [DEPTH];
  logic [31:0] gpio;

  dec_t        w_dec;
  dec_t        r_dec;
  logic        w_ok;
  logic        w_ram_en;
  logic        w_io_en;
  logic        r_ok;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ram_word;
  logic [31:0] src_word;
  logic [31:0] shifted;

  // Classify one access: target region, alignment and legality.
  function automatic dec_t decode(input logic [31:0] addr, input logic [1:0] size);
    dec_t d;
    d.ram   = (addr[31:DATA_ADDR_WIDTH] == '0);
    d.io    = (addr[31:2] == IO_BASE[31:2]);
    d.fault = (size == 2'b11) || !(d.ram || d.io);
    d.mis   = ((size == 2'b01) && addr[0]) ||
              ((size == 2'b10) && (addr[1:0] != 2'b00));
    return d;
  endfunction

  // Decode only the active requests so floating addresses never reach the flags.
  always_comb begin
    w_dec = '0;
    r_dec = '0;
    if (wd && !rst) w_dec = decode(addr_in, size_in);
    if (rd && !rst) r_dec = decode(addr_out, size_out);
    w_ok            = wd && !rst && !w_dec.mis && !w_dec.fault;
    r_ok            = rd && !rst && !r_dec.mis && !r_dec.fault;
    w_ram_en        = w_ok && w_dec.ram;
    w_io_en         = w_ok && w_dec.io;
    addr_misaligned = w_dec.mis | r_dec.mis;
    access_fault    = w_dec.fault | r_dec.fault;
  end

  // Byte-lane enables and lane-replicated write data for the write size.
  always_comb begin
    be    = 4'b1111;
    wdata = data_in;
    case (size_in)
      2'b00: begin
        be    = 4'b0001 << addr_in[1:0];
        wdata = {4{data_in[7:0]}};
      end
      2'b01: begin
        be    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_in;
      end
    endcase
  end

  // RAM write port; contents survive reset, reset only blocks the write.
  always_ff @(posedge clk) begin
    if (w_ram_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[{addr_in[DATA_ADDR_WIDTH-1:2], k[1:0]}] <= wdata[8*k +: 8];
      end
    end
  end

  // Output register with per-byte writes, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio <= '0;
    end else if (w_io_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) gpio[8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Combinational read: fetch the containing word, shift, zero-extend.
  always_comb begin
    ram_word = {mem[{addr_out[DATA_ADDR_WIDTH-1:2], 2'd3}],
                mem[{addr_out[DATA_ADDR_WIDTH-1:2], 2'd2}],
                mem[{addr_out[DATA_ADDR_WIDTH-1:2], 2'd1}],
                mem[{addr_out[DATA_ADDR_WIDTH-1:2], 2'd0}]};
    src_word = r_dec.io ? gpio : ram_word;
    shifted  = src_word >> {addr_out[1:0], 3'b000};
    data_out = '0;
    if (r_ok) begin
      case (size_out)
        2'b00:   data_out = {24'h0, shifted[7:0]};
        2'b01:   data_out = {16'h0, shifted[15:0]};
        default: data_out = src_word;
      endcase
    end
  end

  assign gpio_out = gpio;
  assign busy     = 1'b0;

endmodule

// File: tb/tb_data_bus_control.sv
// Directed self-checking bench for data_bus_control.
module tb_data_bus_control;

  localparam logic [31:0] IO   = 32'h8000_0000;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
  localparam logic [1:0]  B    = 2'b00;
  localparam logic [1:0]  H    = 2'b01;
  localparam logic [1:0]  W    = 2'b10;
  localparam logic [1:0]  R    = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wd = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic [1:0]  size_out = 2'b00;
  logic [31:0] addr_in = IDLE;
  logic [31:0] addr_out = IDLE;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        busy;
  logic        addr_misaligned;
  logic        access_fault;
  logic [31:0] gpio_out;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  data_bus_control #(.DATA_ADDR_WIDTH(10), .IO_BASE(IO)) dut (
    .clk(clk), .rst(rst), .wd(wd), .rd(rd),
    .size_in(size_in), .size_out(size_out),
    .addr_in(addr_in), .addr_out(addr_out), .data_in(data_in),
    .data_out(data_out), .busy(busy),
    .addr_misaligned(addr_misaligned), .access_fault(access_fault),
    .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle's request at the falling edge; inactive addresses get garbage.
  task automatic applyStimulus(input logic w, input logic r,
                               input logic [1:0] szi, input logic [1:0] szo,
                               input logic [31:0] ai, input logic [31:0] ao,
                               input logic [31:0] di);
    @(negedge clk);
    wd       = w;
    rd       = r;
    size_in  = szi;
    size_out = szo;
    addr_in  = w ? ai : IDLE;
    addr_out = r ? ao : IDLE;
    data_in  = di;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset: legal IO write and read are blocked and all outputs are quiet.
    applyStimulus(1, 1, W, W, IO, IO, 32'hFFFF_FFFF);
    checkOutput("rst_data_out", data_out, 32'h0);
    checkOutput("rst_misaligned", 32'(addr_misaligned), 32'h0);
    checkOutput("rst_fault", 32'(access_fault), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_gpio", gpio_out, 32'h0);
    rst = 1'b0;

    // Preload words used by later steps.
    applyStimulus(1, 0, W, B, 32'h04, 0, 32'h1122_3344);
    applyStimulus(1, 0, W, B, 32'h20, 0, 32'h0);
    applyStimulus(1, 0, W, B, 32'h30, 0, 32'h0102_0304);
    checkOutput("gpio_after_release", gpio_out, 32'h0);

    // Word write then word and byte reads.
    applyStimulus(1, 0, W, B, 32'h10, 0, 32'hDEAD_BEEF);
    checkOutput("word_write_flags", {30'h0, addr_misaligned, access_fault}, 32'h0);
    applyStimulus(0, 1, B, W, 0, 32'h10, 0);
    checkOutput("word_read_10", data_out, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, B, B, 0, 32'h10 + i, 0);
      checkOutput($sformatf("byte_read_%0d", i), data_out, {24'h0, exp_bytes[i]});
    end

    // Byte write uses only the low byte of data_in.
    applyStimulus(1, 0, B, B, 32'h11, 0, 32'hFFFF_FF55);
    applyStimulus(0, 1, B, W, 0, 32'h10, 0);
    checkOutput("word_read_after_byte", data_out, 32'hDEAD_55EF);
    applyStimulus(0, 1, B, H, 0, 32'h12, 0);
    checkOutput("half_read_12", data_out, 32'h0000_DEAD);

    // Misaligned accesses are flagged and suppressed.
    applyStimulus(1, 0, W, B, 32'h06, 0, 32'hFFFF_FFFF);
    checkOutput("mis_word_write", 32'(addr_misaligned), 32'h1);
    checkOutput("mis_word_write_fault", 32'(access_fault), 32'h0);
    applyStimulus(0, 1, B, W, 0, 32'h04, 0);
    checkOutput("mem_unchanged_04", data_out, 32'h1122_3344);
    applyStimulus(0, 1, B, H, 0, 32'h03, 0);
    checkOutput("mis_half_read", 32'(addr_misaligned), 32'h1);
    checkOutput("mis_half_read_data", data_out, 32'h0);
    applyStimulus(0, 1, B, H, 0, 32'h06, 0);
    checkOutput("half_read_06", data_out, 32'h0000_1122);
    applyStimulus(1, 0, B, B, 32'h07, 0, 32'h0000_0099);
    checkOutput("byte_odd_not_mis", 32'(addr_misaligned), 32'h0);
    applyStimulus(1, 0, H, B, 32'h04, 0, 32'hABCD_7766);
    applyStimulus(0, 1, B, W, 0, 32'h04, 0);
    checkOutput("byte_half_merge_04", data_out, 32'h9922_7766);

    // Faults: unmapped address, just past RAM, reserved size.
    applyStimulus(1, 0, W, B, 32'h4000_0000, 0, 32'h1234_5678);
    checkOutput("fault_unmapped_write", 32'(access_fault), 32'h1);
    applyStimulus(0, 1, B, W, 0, 32'h0000_0400, 0);
    checkOutput("fault_past_ram", 32'(access_fault), 32'h1);
    checkOutput("fault_past_ram_data", data_out, 32'h0);
    applyStimulus(1, 0, R, B, 32'h10, 0, 32'h0);
    checkOutput("fault_size11_write", 32'(access_fault), 32'h1);
    applyStimulus(0, 1, B, R, 0, 32'h10, 0);
    checkOutput("fault_size11_read", 32'(access_fault), 32'h1);
    checkOutput("fault_size11_data", data_out, 32'h0);
    applyStimulus(0, 1, B, W, 0, 32'h10, 0);
    checkOutput("mem_unchanged_10", data_out, 32'hDEAD_55EF);
    applyStimulus(0, 0, B, W, 0, 32'h10, 0);
    checkOutput("rd_low_data", data_out, 32'h0);

    // Flags from both requests are combined.
    applyStimulus(1, 1, R, W, 32'h10, 32'h12, 0);
    checkOutput("or_flags", {30'h0, addr_misaligned, access_fault}, 32'h3);

    // Output register writes and reads.
    applyStimulus(1, 0, W, B, IO, 0, 32'h1234_5678);
    checkOutput("gpio_before_edge", gpio_out, 32'h0);
    applyStimulus(1, 0, B, B, IO + 32'h2, 0, 32'h0000_00AB);
    checkOutput("gpio_word", gpio_out, 32'h1234_5678);
    applyStimulus(0, 1, B, H, 0, IO + 32'h2, 0);
    checkOutput("gpio_byte_write", gpio_out, 32'h12AB_5678);
    checkOutput("gpio_half_read", data_out, 32'h0000_12AB);

    // Asynchronous reset mid-cycle; writes during reset are aborted.
    applyStimulus(0, 0, B, B, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("gpio_async_reset", gpio_out, 32'h0);
    applyStimulus(1, 1, W, W, IO, IO, 32'hFFFF_FFFF);
    checkOutput("rst_io_read", data_out, 32'h0);
    applyStimulus(1, 0, W, B, 32'h30, 0, 32'hCAFE_F00D);
    applyStimulus(0, 0, B, B, 0, 0, 0);
    checkOutput("gpio_write_blocked", gpio_out, 32'h0);
    rst = 1'b0;
    applyStimulus(0, 1, B, W, 0, 32'h30, 0);
    checkOutput("ram_write_aborted", data_out, 32'h0102_0304);

    // Simultaneous read and write to the same word is read-before-write.
    applyStimulus(1, 1, W, W, 32'h20, 32'h20, 32'hA5A5_A5A5);
    checkOutput("rbw_before_edge", data_out, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rbw_after_edge", data_out, 32'hA5A5_A5A5);
    applyStimulus(0, 0, B, B, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_bus_control.md
DATA_BUS_CONTROL -- requirements
Module: data_bus_control

Interface
REQ-001 The block SHALL have parameter DATA_ADDR_WIDTH, default 10, giving the data RAM size as 2**DATA_ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter IO_BASE, default 32'h8000_0000, giving the address of the memory-mapped output register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port wd, input, 1 bit: write request.
REQ-006 The block SHALL have port rd, input, 1 bit: read request.
REQ-007 The block SHALL have port size_in, input, 2 bits: write size, where 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 The block SHALL have port size_out, input, 2 bits: read size, encoded as for size_in.
REQ-009 The block SHALL have port addr_in, input, 32 bits: write byte address.
REQ-010 The block SHALL have port addr_out, input, 32 bits: read byte address.
REQ-011 The block SHALL have port data_in, input, 32 bits: write data; the low byte, half or word is used according to size_in.
REQ-012 The block SHALL have port data_out, output, 32 bits: read data, zero-extended; sign extension is the core's job.
REQ-013 The block SHALL have port busy, output, 1 bit: bus stall request.
REQ-014 The block SHALL have port addr_misaligned, output, 1 bit: the current access is misaligned.
REQ-015 The block SHALL have port access_fault, output, 1 bit: the current access targets an unmapped address or uses a reserved size.
REQ-016 The block SHALL have port gpio_out, output, 32 bits: contents of the IO output register.

Function
REQ-017 The RAM SHALL be byte-addressed and little-endian, mapped at 0 .. 2**DATA_ADDR_WIDTH-1.
REQ-018 IO_BASE SHALL map the 32-bit gpio register; IO_BASE is word-aligned.
REQ-019 Any other address SHALL be unmapped.
REQ-020 A write SHALL commit on the rising clk edge when wd=1 and the access is legal; byte and half writes modify only the addressed bytes.
REQ-021 A read SHALL be combinational: when rd=1 and the access is legal, data_out holds the addressed byte (bits 7:0) or half (bits 15:0) or word, with upper bits 0, in the same cycle.
REQ-022 When rd=0, or the read is illegal, data_out SHALL be 0.
REQ-023 Alignment rules: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL assert addr_misaligned.
REQ-024 A byte access SHALL never be misaligned.
REQ-025 An unmapped address or size 11 SHALL assert access_fault.
REQ-026 An illegal write SHALL be suppressed, with no state change.
REQ-027 addr_misaligned and access_fault SHALL be combinational and evaluated for the active request(s); they SHALL be OR-ed when wd and rd are both 1.
REQ-028 The flags SHALL be 0 when wd=0 and rd=0.
REQ-029 When wd=1 and rd=1 in the same cycle, the read SHALL return the pre-edge contents, including when the addresses are equal (read-before-write).
REQ-030 The gpio register SHALL accept byte, half and word writes at IO_BASE+offset within the word, and SHALL be readable under the same rules.
REQ-031 busy SHALL be 0 constantly, since every access completes in one cycle.
REQ-032 addr_in and addr_out MAY be high-Z when the matching request is inactive; the block SHALL ignore them then, and no X SHALL propagate to any output.

Reset
REQ-033 While rst=1, asynchronously, gpio_out SHALL be 0 and writes SHALL be blocked.
REQ-034 While rst=1, data_out, addr_misaligned and access_fault SHALL be 0, and busy SHALL be 0.
REQ-035 RAM contents SHALL NOT be cleared by reset; RAM is initialised to 0 at power-up only.
REQ-036 Asserting rst during a write cycle SHALL abort that write.

Verification
REQ-037 Word write 32'hDEADBEEF to 0x10, then word read of 0x10 -> data_out = 32'hDEADBEEF; byte reads of 0x10..0x13 -> 0xEF, 0xBE, 0xAD, 0xDE.
REQ-038 Byte write 0x55 to 0x11 over the REQ-037 contents, then word read of 0x10 -> 32'hDEAD55EF; half read of 0x12 -> 32'h0000DEAD.
REQ-039 Word write to 0x06 and half read of 0x03 -> addr_misaligned = 1 for each, and memory is unchanged.
REQ-040 Write to 0x4000_0000, or with size 11 -> access_fault = 1, and data_out = 0 on read.
REQ-041 Word write 32'h12345678 to IO_BASE -> gpio_out = 32'h12345678 next edge; asserting rst mid-cycle -> gpio_out = 0 immediately.
REQ-042 With wd = rd = 1 at 0x20 (old value 0, new value 32'hA5A5A5A5) -> data_out = 0 before the edge and 32'hA5A5A5A5 after it.
